// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream packet FIFO.
package axis_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_USER_W = 1;

    // One stored beat at the default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] tdata;
        logic [DEF_USER_W-1:0] tuser;
        logic                  tlast;
    } entry_t;

    // Oversize-packet discard state machine.
    typedef enum logic [0:0] {
        StIdle,
        StDrop
    } drop_state_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned sat_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Flop-array storage: synchronous write, asynchronous (fall-through) read.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter type         word_t = entry_t,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  word_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output word_t         rd_data
);

    word_t mem [DEPTH];

    // Write port: storage is not reset, pointers alone define validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FIFO with cut-through or store-and-forward packet mode,
// oversize-packet drop, fill level, almost-full and saturating credit count.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned USER_W      = 1,
    parameter int unsigned PACKET_MODE = 0,
    parameter int unsigned MAX_CNT     = 3,
    parameter int unsigned AFULL_THR   = 12,
    localparam int unsigned LW         = $clog2(DEPTH) + 1,
    localparam int unsigned SW         = $clog2(MAX_CNT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tlast,
    output logic [LW-1:0]     level,
    output logic [SW-1:0]     spots,
    output logic              almost_full,
    output logic              pkt_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam bit          PM = (PACKET_MODE != 0);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("axis_pkt_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
        $error("axis_pkt_fifo: AFULL_THR must be within 1..DEPTH");
    end
    if (MAX_CNT < 1) begin : g_bad_max_cnt
        $error("axis_pkt_fifo: MAX_CNT must be >= 1");
    end

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [USER_W-1:0] tuser;
        logic              tlast;
    } beat_t;

    logic [PW-1:0] wr_ptr, rd_ptr, wptr_c, pkt_cnt;
    drop_state_t   state;
    logic          pkt_drop_q;
    logic          ptr_empty, ptr_full, dropping, enter_drop;
    logic          wr_fire, rd_fire, store, pkt_inc, pkt_dec;
    logic [PW-1:0] level_raw;
    logic [31:0]   free_cnt;
    beat_t         wr_beat, rd_beat;

    assign ptr_empty = (wr_ptr == rd_ptr);
    assign ptr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dropping  = PM && (state == StDrop);
    // A partial packet that fills the FIFO can never complete, so discard it.
    assign enter_drop = PM && (state == StIdle) && ptr_full && (pkt_cnt == '0);

    // s_tready depends only on registered state, never on m_tready.
    assign s_axis_tready = !reset && (!ptr_full || dropping);
    assign m_axis_tvalid = !reset && (PM ? (pkt_cnt != '0) : !ptr_empty);

    assign wr_fire = s_axis_tvalid && s_axis_tready;
    assign rd_fire = m_axis_tvalid && m_axis_tready;
    assign store   = wr_fire && !dropping;
    assign pkt_inc = PM && store && s_axis_tlast;
    assign pkt_dec = PM && rd_fire && m_axis_tlast;

    assign wr_beat = '{tdata: s_axis_tdata, tuser: s_axis_tuser, tlast: s_axis_tlast};

    axis_fifo_ram #(
        .DEPTH  (DEPTH),
        .word_t (beat_t)
    ) u_ram (
        .clock   (clock),
        .wr_en   (store),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_beat)
    );

    assign m_axis_tdata = rd_beat.tdata;
    assign m_axis_tuser = rd_beat.tuser;
    assign m_axis_tlast = rd_beat.tlast;

    // Read, write and commit pointers; entering drop rewinds the write side.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wptr_c <= '0;
        end else begin
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enter_drop) begin
                wr_ptr <= wptr_c;
            end else if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (PM && s_axis_tlast) begin
                    wptr_c <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // Count of complete packets held; simultaneous in/out leaves it unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_cnt <= '0;
        end else if (pkt_inc && !pkt_dec) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end else if (pkt_dec && !pkt_inc) begin
            pkt_cnt <= pkt_cnt - 1'b1;
        end
    end

    // Drop FSM: swallow beats until the oversize packet's tlast, then pulse pkt_drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            pkt_drop_q <= 1'b0;
        end else begin
            pkt_drop_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (enter_drop) begin
                        state <= StDrop;
                    end
                end
                StDrop: begin
                    if (wr_fire && s_axis_tlast) begin
                        state      <= StIdle;
                        pkt_drop_q <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Status outputs, forced to their idle values while reset is held.
    always_comb begin
        level_raw   = wr_ptr - rd_ptr;
        free_cnt    = 32'(DEPTH) - 32'(level_raw);
        level       = reset ? '0 : level_raw;
        spots       = reset ? SW'(sat_min(DEPTH, MAX_CNT)) : SW'(sat_min(free_cnt, MAX_CNT));
        almost_full = !reset && (32'(level_raw) >= AFULL_THR);
        pkt_drop    = !reset && pkt_drop_q;
    end

endmodule
